// File: rtl/mult_arbiter_pkg.sv
// Shared types and default sizing for the round-robin shared multiplier.
package mult_pkg;
  localparam int MULT_WIDTH = 8;
  localparam int MULT_N_REQ = 4;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } mult_state_t;
endpackage

// File: rtl/mult_arbiter_if.sv
// Request/response bundle between clients and the shared multiplier.
interface mult_arbiter_if
  import mult_pkg::*;
#(
  parameter int N_REQ = MULT_N_REQ,
  parameter int WIDTH = MULT_WIDTH,
  parameter int ID_W  = $clog2(N_REQ)
);
  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ-1:0]       req_ready;
  logic [N_REQ*WIDTH-1:0] req_a;
  logic [N_REQ*WIDTH-1:0] req_b;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [ID_W-1:0]        rsp_id;
  logic [2*WIDTH-1:0]     rsp_product;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_product
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_product
  );
endinterface

// File: rtl/mult_arbiter_core.sv
// Iterative shift-and-add multiplier: WIDTH steps per product, no early exit.
module rpm_iter_core
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [2*WIDTH-1:0] a_reg;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   b_reg;
  logic [CNT_W-1:0]   cnt;
  logic               running;

  // done marks the final step so the FSM lands in DONE right after it
  assign done    = running && (cnt == CNT_W'(WIDTH - 1));
  assign product = acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg   <= '0;
      b_reg   <= '0;
      acc     <= '0;
      cnt     <= '0;
      running <= 1'b0;
    end else if (start) begin
      a_reg   <= {{WIDTH{1'b0}}, a};
      b_reg   <= b;
      acc     <= '0;
      cnt     <= '0;
      running <= 1'b1;
    end else if (running) begin
      if (b_reg[0]) acc <= acc + a_reg;
      a_reg <= a_reg << 1;
      b_reg <= b_reg >> 1;
      cnt   <= cnt + 1'b1;
      if (done) running <= 1'b0;
    end
  end
endmodule

// File: rtl/mult_arbiter.sv
// Round-robin arbiter and control FSM sharing one rpm_iter_core among N_REQ clients.
module mult_arbiter
  import mult_pkg::*;
#(
  parameter int N_REQ = MULT_N_REQ,
  parameter int WIDTH = MULT_WIDTH,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic           clk,
  input  logic           rst_n,
  mult_arbiter_if.slave  bus,
  output logic           busy
);
  mult_state_t          state;
  logic [ID_W-1:0]      ptr;
  logic [ID_W-1:0]      id_reg;
  logic [ID_W-1:0]      win_id;
  logic                 any_valid;
  logic                 start;
  logic                 core_done;
  logic                 rsp_valid_r;
  logic [N_REQ-1:0]     grant;
  logic [WIDTH-1:0]     a_sel;
  logic [WIDTH-1:0]     b_sel;
  logic [2*WIDTH-1:0]   product;
  int                   idx;

  // Search starts at ptr so the last-served requester ends up lowest priority
  always_comb begin
    win_id    = '0;
    any_valid = 1'b0;
    idx       = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!any_valid && bus.req_valid[idx]) begin
        any_valid = 1'b1;
        win_id    = ID_W'(idx);
      end
    end
  end

  always_comb begin
    grant = '0;
    if (state == IDLE && any_valid) grant[win_id] = 1'b1;
  end

  assign start           = (state == IDLE) && any_valid;
  assign a_sel           = bus.req_a[int'(win_id)*WIDTH +: WIDTH];
  assign b_sel           = bus.req_b[int'(win_id)*WIDTH +: WIDTH];
  assign bus.req_ready   = grant;
  assign bus.rsp_valid   = rsp_valid_r;
  assign bus.rsp_id      = id_reg;
  assign bus.rsp_product = product;

  rpm_iter_core #(.WIDTH(WIDTH)) u_core (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a       (a_sel),
    .b       (b_sel),
    .done    (core_done),
    .product (product)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      ptr         <= '0;
      id_reg      <= '0;
      rsp_valid_r <= 1'b0;
      busy        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            id_reg <= win_id;
            busy   <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          if (core_done) begin
            rsp_valid_r <= 1'b1;
            state       <= DONE;
          end
        end
        DONE: begin
          if (bus.rsp_ready) begin
            rsp_valid_r <= 1'b0;
            busy        <= 1'b0;
            ptr         <= (id_reg == ID_W'(N_REQ - 1)) ? '0 : id_reg + 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mult_arbiter.sv
// Directed bench for mult_arbiter: latency, edge operands, round-robin, backpressure, reset abort.
module tb_mult_arbiter;
  localparam int N = 4;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  mult_arbiter_if #(.N_REQ(N), .WIDTH(W)) bus ();

  mult_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .busy  (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int id, input int a, input int b);
    bus.req_a[id*W +: W] = W'(a);
    bus.req_b[id*W +: W] = W'(b);
  endtask

  // Returns one cycle after the handshake edge (first RUN cycle)
  task automatic wait_grant(input int id, input string tag);
    int n = 0;
    #1;
    while (!bus.req_ready[id] && n < 40) begin
      step();
      n++;
    end
    chk({tag, "_grant"}, 32'(bus.req_ready), 32'(1 << id));
    step();
  endtask

  // Returns in the first DONE cycle, before the response handshake edge
  task automatic wait_rsp(input int id, input int prod, input string tag);
    int n = 0;
    while (!bus.rsp_valid && n < 40) begin
      step();
      n++;
    end
    chk({tag, "_valid"}, 32'(bus.rsp_valid), 1);
    chk({tag, "_id"}, 32'(bus.rsp_id), 32'(id));
    chk({tag, "_prod"}, 32'(bus.rsp_product), 32'(prod));
    chk({tag, "_noready"}, 32'(bus.req_ready), 0);
  endtask

  int e_id[4]   = '{1, 2, 3, 3};
  int e_a[4]    = '{0, 255, 255, 1};
  int e_b[4]    = '{25, 255, 1, 255};
  int e_p[4]    = '{0, 65025, 255, 255};
  int f_p[4]    = '{150, 63, 100, 9};

  initial begin
    int n;
    int seen;
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b1;
    #2;
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
    chk("rst_rsp_id", 32'(bus.rsp_id), 0);
    chk("rst_rsp_product", 32'(bus.rsp_product), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_req_ready", 32'(bus.req_ready), 0);
    step();
    step();
    rst_n = 1'b1;
    step();

    // single request with latency check
    set_op(0, 13, 12);
    bus.req_valid = 4'b0001;
    wait_grant(0, "single");
    bus.req_valid = '0;
    chk("single_busy", 32'(busy), 1);
    n = 0;
    while (!bus.rsp_valid && n < 40) begin
      step();
      n++;
    end
    chk("single_latency", 32'(n), 32'(W));
    chk("single_prod", 32'(bus.rsp_product), 156);
    chk("single_id", 32'(bus.rsp_id), 0);
    step();
    chk("single_idle_valid", 32'(bus.rsp_valid), 0);
    chk("single_idle_busy", 32'(busy), 0);

    // edge operands; the first is issued in the cycle right after the response
    for (int i = 0; i < 4; i++) begin
      set_op(e_id[i], e_a[i], e_b[i]);
      bus.req_valid[e_id[i]] = 1'b1;
      wait_grant(e_id[i], $sformatf("edge%0d", i));
      bus.req_valid = '0;
      wait_rsp(e_id[i], e_p[i], $sformatf("edge%0d", i));
      step();
    end

    // all four requesters continuously asserted
    set_op(0, 15, 10);
    set_op(1, 7, 9);
    set_op(2, 20, 5);
    set_op(3, 3, 3);
    bus.req_valid = 4'b1111;
    for (int r = 0; r < 5; r++) begin
      n = 0;
      while (!bus.rsp_valid && n < 40) begin
        chk("all_onehot", 32'($countones(bus.req_ready) <= 1), 1);
        step();
        n++;
      end
      chk($sformatf("all%0d_valid", r), 32'(bus.rsp_valid), 1);
      chk($sformatf("all%0d_id", r), 32'(bus.rsp_id), 32'(r % 4));
      chk($sformatf("all%0d_prod", r), 32'(bus.rsp_product), 32'(f_p[r % 4]));
      if (r == 4) bus.req_valid = '0;
      step();
    end

    // backpressure, ptr now 1
    set_op(1, 11, 13);
    set_op(2, 6, 7);
    bus.rsp_ready = 1'b0;
    bus.req_valid = 4'b0110;
    wait_grant(1, "bp");
    bus.req_valid = 4'b0100;
    wait_rsp(1, 143, "bp");
    for (int c = 0; c < 5; c++) begin
      step();
      chk("bp_hold_valid", 32'(bus.rsp_valid), 1);
      chk("bp_hold_prod", 32'(bus.rsp_product), 143);
      chk("bp_hold_id", 32'(bus.rsp_id), 1);
      chk("bp_hold_noready", 32'(bus.req_ready), 0);
    end
    bus.rsp_ready = 1'b1;
    step();
    chk("bp_next_grant", 32'(bus.req_ready), 32'(4'b0100));

    // round-robin from a nonzero pointer
    wait_grant(2, "rr2");
    bus.req_valid = '0;
    wait_rsp(2, 42, "rr2");
    set_op(1, 5, 4);
    set_op(3, 9, 8);
    bus.req_valid = 4'b1010;
    step();
    chk("rr_pick3", 32'(bus.req_ready), 32'(4'b1000));
    wait_grant(3, "rr3");
    bus.req_valid = 4'b0010;
    wait_rsp(3, 72, "rr3");
    step();
    wait_grant(1, "rr1");
    bus.req_valid = '0;
    wait_rsp(1, 20, "rr1");
    step();

    // reset in the 4th RUN cycle
    set_op(0, 200, 100);
    bus.req_valid = 4'b0001;
    wait_grant(0, "abort");
    bus.req_valid = '0;
    step();
    step();
    step();
    rst_n = 1'b0;
    #1;
    chk("abort_rsp_valid", 32'(bus.rsp_valid), 0);
    chk("abort_rsp_id", 32'(bus.rsp_id), 0);
    chk("abort_rsp_product", 32'(bus.rsp_product), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_req_ready", 32'(bus.req_ready), 0);
    step();
    rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 12; c++) begin
      step();
      if (bus.rsp_valid) seen++;
    end
    chk("abort_no_rsp", 32'(seen), 0);
    set_op(1, 7, 9);
    set_op(2, 3, 3);
    bus.req_valid = 4'b0110;
    #1;
    chk("abort_ptr0", 32'(bus.req_ready), 32'(4'b0010));
    wait_grant(1, "post");
    bus.req_valid = '0;
    wait_rsp(1, 63, "post");
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mult_arbiter.md
# mult_arbiter

Shares one iterative shift-and-add (Russian-peasant) multiply engine between `N_REQ` requesters. Each requester has its own valid/ready request channel; one shared response channel returns the product tagged with the requester index. It sits between the arithmetic clients and the multiplier datapath. It replaces per-client combinational multipliers with one area-cheap sequential unit and fair round-robin access.

## Interface
- `N_REQ`, 4: number of requesters (≥2).
- `WIDTH`, 8: operand width; product is `2*WIDTH`.
- `ID_W`, `$clog2(N_REQ)`: derived width of `rsp_id`.

- `clk`  in  1  single clock; all state changes on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req_valid`  in  N_REQ  per-requester request valid.
- `req_ready`  out  N_REQ  per-requester accept; at most one bit high (one-hot or zero).
- `req_a`  in  N_REQ*WIDTH  packed operand A; requester i in bits [i*WIDTH +: WIDTH].
- `req_b`  in  N_REQ*WIDTH  packed operand B, same packing.
- `rsp_valid`  out  1  product valid.
- `rsp_ready`  in  1  response consumer accept.
- `rsp_id`  out  ID_W  index of the requester that owns `rsp_product`.
- `rsp_product`  out  2*WIDTH  unsigned A*B.
- `busy`  out  1  high in every state except IDLE.

## Operation
- States: IDLE, RUN, DONE.
- **IDLE**
  - Winner = first i with `req_valid[i]`, searching from `ptr`, `ptr+1`, … modulo N_REQ.
  - `req_ready[winner]` = 1, combinational from `req_valid` and `ptr`. All other ready bits are 0. With no valid request, all ready bits are 0.
  - On handshake: latch `a_reg` = A zero-extended to 2*WIDTH, `b_reg` = B, `id_reg` = winner. Clear `acc` and `cnt`, then go to RUN.
  - A requester may drop `req_valid` before being granted. The winner is re-evaluated every IDLE cycle.
- **RUN**: exactly WIDTH cycles, no early termination. Each cycle:
  - if `b_reg[0]`, `acc <= acc + a_reg`;
  - `a_reg <<= 1`, `b_reg >>= 1`, `cnt++`.
  - Arithmetic is unsigned, `acc` is 2*WIDTH wide, and overflow is impossible.
  - After the WIDTH-th step, go to DONE.
- **DONE**
  - `rsp_valid` = 1.
  - `rsp_product` = `acc` and `rsp_id` = `id_reg`, both stable while waiting.
  - On `rsp_valid && rsp_ready`: `ptr <= (id_reg+1) mod N_REQ`, then go to IDLE.
- `req_ready` is all-zero in RUN and DONE. Requests are only accepted in IDLE.
- Operands are sampled only at handshake. Later changes on `req_a`/`req_b` have no effect.
- Reset: async clear to IDLE with `ptr`=0, `acc`=0, `cnt`=0 and all registers 0. Outputs: `req_ready`=0 (no valid), `rsp_valid`=0, `rsp_id`=0, `rsp_product`=0, `busy`=0.
- Reset mid-RUN or mid-DONE aborts the operation. No response is issued for it.

## Timing
- Request handshake in cycle T (IDLE).
- RUN occupies T+1 … T+WIDTH.
- `rsp_valid` rises in T+WIDTH+1, i.e. latency WIDTH+1 from acceptance to first response cycle.
- With `rsp_ready` high at T+WIDTH+1, the FSM is in IDLE at T+WIDTH+2 and can accept the next request that cycle. Peak throughput is one product per WIDTH+2 cycles.
- Backpressure: each cycle `rsp_ready`=0 in DONE adds one cycle. Outputs are held.
- Fairness: the winner just served becomes lowest priority. A continuously asserting requester waits at most N_REQ-1 operations.
- `ptr` updates only on response handshake, not on grant.

## Structure
- Shared package `mult_pkg`:
  - state enum `mult_state_t` {IDLE, RUN, DONE};
  - default `WIDTH`/`N_REQ` localparams.
- Sub-module `rpm_iter_core`:
  - holds `a_reg`/`b_reg`/`acc`/`cnt`;
  - inputs: `start`, operands;
  - outputs: `done` pulse in the last RUN cycle, `product`.
- Top-level keeps the arbiter, `ptr`, `id_reg` and the FSM.

## Test plan
- Single request: req0 A=13, B=12, `rsp_ready`=1 → handshake at T, `rsp_valid` at T+9, `rsp_product`=156, `rsp_id`=0. Next grant possible at T+10.
- Edge operands, one at a time: 0×25 → 0; 255×255 → 65025; 255×1 → 255; 1×255 → 255.
- All four requesters assert continuously with distinct operands (15×10, 7×9, 20×5, 3×3) → responses in order id 0,1,2,3 (150, 63, 100, 9), then id 0 again. Never more than one `req_ready` bit high.
- Backpressure: `rsp_ready` low for 5 cycles in DONE → `rsp_valid`, `rsp_product` and `rsp_id` stable. No new `req_ready` until the response handshake.
- Round-robin from a nonzero pointer: serve req2 first, then assert req1 and req3 together → req3 granted before req1.
- Reset asserted in the 4th RUN cycle → all outputs 0 immediately. After release, `ptr`=0, the aborted product never appears, and a new 7×9 request returns 63.
